mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 256: storage size in 16-bit words; power of two, 2..32768.
REQ-002 Parameter LATENCY, default 3: base wait cycles from request acceptance to response; range 1..15.
REQ-003 Port clk  input  1: single clock, all state updates on the rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 Port mem_address  input  16: byte address of the request.
REQ-006 Port mem_read  input  1: read request, held by the initiator until mem_resp.
REQ-007 Port mem_write  input  1: write request, held by the initiator until mem_resp.
REQ-008 Port mem_wdata  input  16: write data.
REQ-009 Port mem_byte_enable  input  2: write lane mask; bit0 = [7:0], bit1 = [15:8].
REQ-010 Port mem_resp  output  1: one-cycle completion pulse.
REQ-011 Port mem_rdata  output  16: read data, valid while mem_resp is high.

Function
REQ-012 FSM states SHALL be IDLE, BUSY, RESP and DONE.
REQ-013 IDLE: on (mem_read | mem_write) at an edge, the block SHALL latch address, wdata, byte_enable and op, and enter BUSY.
REQ-014 Word index SHALL be mem_address[log2(DEPTH):1]; bit0 and higher bits SHALL be ignored, so addresses wrap modulo 2*DEPTH bytes.
REQ-015 BUSY SHALL last exactly LATENCY cycles (plus injected wait, REQ-027), counted by a down-counter, then enter RESP.
REQ-016 RESP SHALL last exactly 1 cycle, with mem_resp = 1; for a read, mem_rdata SHALL hold the word at the latched index.
REQ-017 A write SHALL commit the enabled lanes on the edge entering RESP; disabled lanes SHALL be unchanged; mask 2'b00 SHALL still respond and SHALL change nothing.
REQ-018 Read data SHALL be captured on the edge entering RESP; a read immediately after a write to the same word SHALL return the new data.
REQ-019 DONE SHALL last 1 cycle, ignore all inputs, and return to IDLE, so a request still held after mem_resp is not served twice.
REQ-020 Read and write asserted together SHALL be served as a write only.
REQ-021 Input changes during BUSY, RESP or DONE SHALL have no effect.
REQ-022 Outside RESP, mem_resp SHALL be 0 and mem_rdata SHALL hold its last value.
REQ-023 Minimum request-to-request turnaround SHALL be LATENCY+3 cycles.

Reset
REQ-024 While rst_n = 0: state = IDLE, mem_resp = 0, mem_rdata = 16'h0000, wait counter = 0.
REQ-025 Reset asserted mid-transaction SHALL abort it; an uncommitted write SHALL NOT modify storage.
REQ-026 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-027 With MEM_RESP_STALL_INJECT_EN defined:
- a 4-bit LFSR (x^4+x^3+1, reset seed 4'b1001) SHALL advance every cycle;
- on entry to BUSY, lfsr[1:0] extra wait cycles (0..3) SHALL be added.
REQ-028 Without MEM_RESP_STALL_INJECT_EN: the LFSR SHALL be absent and BUSY SHALL be exactly LATENCY cycles.

Structure
REQ-029 lc3b_word and a new enum lc3b_mresp_state (IDLE, BUSY, RESP, DONE) SHALL live in package lc3b_types.
REQ-030 Storage SHALL be sub-module mem_resp_array (DEPTH x 16, per-lane write enable, synchronous read); the FSM and counter SHALL stay in mem_responder.

Verification (LATENCY = 3, DEPTH = 256, macro undefined unless stated)
REQ-031 Write 16'hBEEF to 16'h0010, mask 2'b11, then read 16'h0010 -> mem_resp 4 cycles after acceptance; rdata = 16'hBEEF.
REQ-032 Preload 16'h1234 at 16'h0020; write 16'hAB00, mask 2'b10; read -> 16'hAB34.
REQ-033 Hold mem_read high for 10 cycles after mem_resp -> exactly one pulse per LATENCY+3 cycles, never in consecutive cycles.
REQ-034 Write 16'h5555 to 16'h0202 (wraps to word 1); read 16'h0002 -> 16'h5555.
REQ-035 Pull rst_n low 2 cycles into a write of 16'hFFFF to 16'h0030 (word holds 16'h0000) -> mem_resp stays 0; later read of 16'h0030 -> 16'h0000.
REQ-036 Macro defined: 8 back-to-back reads -> every acceptance-to-resp gap in 4..7 cycles; gap sequence matches a reference LFSR model.

Source files
------------

// File: rtl/lc3b_types.sv
// -----------------------------------------------------------------------------
// lc3b_types
// Shared types for the memory responder slice.
//   lc3b_word        : 16-bit data word
//   lc3b_mresp_state : responder FSM state (IDLE, BUSY, RESP, DONE)
//   MRESP_CNT_W      : width of the responder wait counter. It must hold
//                      LATENCY-1 plus up to 3 injected stall cycles, i.e. at
//                      most 17, so 5 bits are enough.
// -----------------------------------------------------------------------------
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lc3b_mresp_state;

  localparam int MRESP_CNT_W = 5;

endpackage

// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
// Request/response bus between an initiator and mem_responder.
//   mem_address     : byte address of the request
//   mem_read        : read request, held until mem_resp
//   mem_write       : write request, held until mem_resp
//   mem_wdata       : write data
//   mem_byte_enable : write lane mask (bit0 = [7:0], bit1 = [15:8])
//   mem_resp        : one-cycle completion pulse
//   mem_rdata       : read data, valid while mem_resp is high
// Modports: master (initiator side), slave (responder side).
// -----------------------------------------------------------------------------
interface mem_responder_if;
  import lc3b_types::*;

  logic [15:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  lc3b_word    mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  lc3b_word    mem_rdata;

  modport master (
    output mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable,
    input  mem_resp, mem_rdata
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable,
    output mem_resp, mem_rdata
  );

endinterface

// File: rtl/mem_resp_array.sv
// -----------------------------------------------------------------------------
// mem_resp_array
// DEPTH x 16-bit storage with per-byte-lane write enable and a synchronous,
// enabled read port.
//   clk   : clock
//   rst_n : async active-low reset, clears only the read-data register
//   addr  : word index
//   we    : write strobe, lanes selected by be
//   be    : lane mask (bit0 = [7:0], bit1 = [15:8])
//   wdata : write data
//   re    : read strobe; rdata is loaded on the edge where re is high
//   rdata : read data register, holds its value between reads
// Storage itself is never reset.
// -----------------------------------------------------------------------------
module mem_resp_array
  import lc3b_types::*;
#(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [1:0]    be,
  input  lc3b_word      wdata,
  input  logic          re,
  output lc3b_word      rdata
);

  lc3b_word mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      if (be[0]) mem[addr][7:0]  <= wdata[7:0];
      if (be[1]) mem[addr][15:8] <= wdata[15:8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Fixed-latency memory responder. A request seen in IDLE is latched and the
// FSM waits LATENCY cycles in BUSY, then pulses mem_resp for one cycle in
// RESP, then spends one cycle in DONE ignoring inputs so that a request still
// held after mem_resp is not served twice. Turnaround is LATENCY+3 cycles.
//   clk   : clock
//   rst_n : async active-low reset (aborts any transaction, storage kept)
//   bus   : mem_responder_if.slave request/response bus
// Parameters:
//   DEPTH   : storage words (power of two, 2..32768)
//   LATENCY : base BUSY cycles (1..15)
// Optional feature macro: MEM_RESP_STALL_INJECT_EN
//   When defined, a 4-bit LFSR (x^4+x^3+1, seed 4'b1001) runs every cycle and
//   lfsr[1:0] extra BUSY cycles are added at request acceptance.
// -----------------------------------------------------------------------------
module mem_responder
  import lc3b_types::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = MRESP_CNT_W;

  lc3b_mresp_state state;
  logic [CW-1:0]   wait_cnt;
  logic            resp_q;

  logic [AW-1:0]   idx_q;
  lc3b_word        wdata_q;
  logic [1:0]      be_q;
  logic            op_write_q;

  logic            req;
  logic            accept;
  logic            last_busy;
  logic            arr_we;
  logic            arr_re;
  logic [CW-1:0]   extra_wait;
  logic [CW-1:0]   start_cnt;
  lc3b_word        arr_rdata;
  logic            unused_addr;

  assign req    = bus.mem_read | bus.mem_write;
  assign accept = (state == IDLE) && req;

  // Address bit 0 and bits above the index are don't-care (byte address,
  // wraps modulo 2*DEPTH bytes).
  assign unused_addr = ^bus.mem_address;

`ifdef MEM_RESP_STALL_INJECT_EN
  logic [3:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 4'b1001;
    end else begin
      lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end
  end

  assign extra_wait = {{(CW-2){1'b0}}, lfsr[1:0]};
`else
  assign extra_wait = '0;
`endif

  // Counter is loaded with (cycles - 1) so BUSY exits when it reads zero.
  assign start_cnt = CW'(LATENCY - 1) + extra_wait;

  // The last BUSY cycle is the one whose closing edge enters RESP: both the
  // write commit and the read capture happen on that edge.
  assign last_busy = (state == BUSY) && (wait_cnt == '0);
  assign arr_we    = last_busy && op_write_q;
  assign arr_re    = last_busy && !op_write_q;

  // Request capture (data path, no reset needed: only used while in BUSY)
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q      <= bus.mem_address[AW:1];
      wdata_q    <= bus.mem_wdata;
      be_q       <= bus.mem_byte_enable;
      op_write_q <= bus.mem_write;  // read+write together is a write
    end
  end

  // Control FSM with registered mem_resp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      resp_q   <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            state    <= BUSY;
            wait_cnt <= start_cnt;
          end
        end
        BUSY: begin
          if (wait_cnt == '0) begin
            state  <= RESP;
            resp_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        RESP:    state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  mem_resp_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (idx_q),
    .we    (arr_we),
    .be    (be_q),
    .wdata (wdata_q),
    .re    (arr_re),
    .rdata (arr_rdata)
  );

  assign bus.mem_resp  = resp_q;
  assign bus.mem_rdata = arr_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Directed self-checking bench for mem_responder (DEPTH=256, LATENCY=3).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_responder;
  import lc3b_types::*;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 3;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mem_responder_if bus ();

  mem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MEM_RESP_STALL_INJECT_EN
  // Reference LFSR: x^4+x^3+1, seed 4'b1001, one step per clock.
  logic [3:0] ref_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ref_lfsr <= 4'b1001;
    else        ref_lfsr <= {ref_lfsr[2:0], ref_lfsr[3] ^ ref_lfsr[2]};
  end
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered at a falling edge with the DUT idle; returns at a falling edge
  // with the DUT idle again. With disturb set, inputs are scrambled one cycle
  // after acceptance, which must not affect the transaction.
  task automatic run_txn(input string tag, input bit rd, input bit wr,
                         input logic [15:0] addr, input logic [15:0] wd,
                         input logic [1:0] be, input bit disturb,
                         output logic [15:0] rdata, output int lat);
    int  k;
    int  exp_lat;
    bit  seen;
    bus.mem_address     = addr;
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_wdata       = wd;
    bus.mem_byte_enable = be;
    exp_lat = LATENCY + 1;
`ifdef MEM_RESP_STALL_INJECT_EN
    exp_lat += int'(ref_lfsr[1:0]);
`endif
    k    = 0;
    seen = 1'b0;
    while (k < 40 && !seen) begin
      @(negedge clk);
      k++;
      if (disturb && k == 1) begin
        bus.mem_address     = addr ^ 16'h0030;
        bus.mem_wdata       = ~wd;
        bus.mem_write       = 1'b1;
        bus.mem_byte_enable = 2'b11;
      end
      if (bus.mem_resp) seen = 1'b1;
    end
    lat   = k;
    rdata = bus.mem_rdata;
    chk({tag, " latency"}, 32'(k), 32'(exp_lat));
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    @(negedge clk);
    chk({tag, " resp low after pulse"}, 32'(bus.mem_resp), 32'd0);
    chk({tag, " rdata held"}, 32'(bus.mem_rdata), 32'(rdata));
    @(negedge clk);
  endtask

  logic [15:0] rd;
  int          lat;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.mem_address     = '0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_wdata       = '0;
    bus.mem_byte_enable = '0;

    repeat (3) @(negedge clk);
    chk("reset mem_resp", 32'(bus.mem_resp), 32'd0);
    chk("reset mem_rdata", 32'(bus.mem_rdata), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full write then read back
    run_txn("wr BEEF", 1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 1'b0, rd, lat);
    run_txn("rd BEEF", 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 1'b0, rd, lat);
    chk("rd BEEF data", 32'(rd), 32'h0000_BEEF);

    // Lane masks
    run_txn("wr 1234", 1'b0, 1'b1, 16'h0020, 16'h1234, 2'b11, 1'b0, rd, lat);
    run_txn("wr AB00 hi", 1'b0, 1'b1, 16'h0020, 16'hAB00, 2'b10, 1'b0, rd, lat);
    run_txn("rd AB34", 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 1'b0, rd, lat);
    chk("rd AB34 data", 32'(rd), 32'h0000_AB34);
    run_txn("wr mask00", 1'b0, 1'b1, 16'h0020, 16'hFFFF, 2'b00, 1'b0, rd, lat);
    run_txn("wr 55CD lo", 1'b0, 1'b1, 16'h0020, 16'h55CD, 2'b01, 1'b0, rd, lat);
    run_txn("rd ABCD", 1'b1, 1'b0, 16'h0021, 16'h0000, 2'b00, 1'b0, rd, lat);
    chk("rd ABCD data", 32'(rd), 32'h0000_ABCD);

    // Read and write together behave as a write
    run_txn("rdwr 0F0F", 1'b1, 1'b1, 16'h0040, 16'h0F0F, 2'b11, 1'b0, rd, lat);
    run_txn("rd 0F0F", 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 1'b0, rd, lat);
    chk("rd 0F0F data", 32'(rd), 32'h0000_0F0F);

    // Address wrap and ignored bit 0
    run_txn("wr 5555 wrap", 1'b0, 1'b1, 16'h0202, 16'h5555, 2'b11, 1'b0, rd, lat);
    run_txn("rd wrap", 1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, 1'b0, rd, lat);
    chk("rd wrap data", 32'(rd), 32'h0000_5555);
    run_txn("rd odd", 1'b1, 1'b0, 16'h0003, 16'h0000, 2'b00, 1'b0, rd, lat);
    chk("rd odd data", 32'(rd), 32'h0000_5555);

    // Inputs changed mid-transaction must be ignored
    run_txn("rd disturbed", 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 1'b1, rd, lat);
    chk("rd disturbed data", 32'(rd), 32'h0000_BEEF);
    run_txn("rd after disturb", 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 1'b0, rd, lat);
    chk("no stray write", 32'(rd), 32'h0000_ABCD);

`ifndef MEM_RESP_STALL_INJECT_EN
    // Held read: one pulse every LATENCY+3 cycles, never back-to-back
    begin
      int pulses;
      int prev;
      pulses = 0;
      prev   = -100;
      bus.mem_address = 16'h0010;
      bus.mem_read    = 1'b1;
      for (int c = 1; c <= 23; c++) begin
        @(negedge clk);
        if (bus.mem_resp) begin
          pulses++;
          chk("held rd data", 32'(bus.mem_rdata), 32'h0000_BEEF);
          if (pulses == 1) chk("held first pulse", 32'(c), 32'(LATENCY + 1));
          else             chk("held pulse spacing", 32'(c - prev), 32'(LATENCY + 3));
          prev = c;
        end
      end
      bus.mem_read = 1'b0;
      chk("held pulse count", 32'(pulses), 32'd4);
      @(negedge clk);
    end
`endif

    // Reset in the middle of a write aborts it
    run_txn("wr 0000", 1'b0, 1'b1, 16'h0030, 16'h0000, 2'b11, 1'b0, rd, lat);
    begin
      int pulses;
      pulses = 0;
      bus.mem_address     = 16'h0030;
      bus.mem_wdata       = 16'hFFFF;
      bus.mem_byte_enable = 2'b11;
      bus.mem_write       = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort resp in reset", 32'(bus.mem_resp), 32'd0);
      @(negedge clk);
      chk("abort rdata in reset", 32'(bus.mem_rdata), 32'h0);
      @(negedge clk);
      bus.mem_write = 1'b0;
      rst_n = 1'b1;
      repeat (8) begin
        @(negedge clk);
        if (bus.mem_resp) pulses++;
      end
      chk("abort no resp", 32'(pulses), 32'd0);
    end
    run_txn("rd aborted", 1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, 1'b0, rd, lat);
    chk("rd aborted data", 32'(rd), 32'h0);

`ifdef MEM_RESP_STALL_INJECT_EN
    // Back-to-back reads with stall injection; latency also checked per txn
    for (int i = 0; i < 8; i++) begin
      run_txn("stall rd", 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 1'b0, rd, lat);
      chk("stall gap in range", 32'((lat >= 4) && (lat <= 7)), 32'd1);
      chk("stall rd data", 32'(rd), 32'h0000_BEEF);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
